// File: rtl/npc_pkg.sv
// Shared encodings for the NPC sprite layer: game states, facing directions
// and screen coordinate widths.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2
  } npc_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int X_W = 10;
  localparam int Y_W = 9;

endpackage

// File: rtl/npc_anim_div.sv
// Tick divider plus animation frame counter. wrap pulses combinationally in
// the enabled cycle that takes the frame from NUM_FRAMES-1 back to 0.
module npc_anim_div #(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 16,
  localparam int FW = $clog2(NUM_FRAMES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  output logic [FW-1:0] frame,
  output logic          wrap
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [DW-1:0] div;
  logic          div_last;
  logic          frame_last;

  assign div_last   = (div == DW'(FRAME_DIV - 1));
  assign frame_last = (frame == FW'(NUM_FRAMES - 1));
  assign wrap       = en && !clear && div_last && frame_last;

  // clear outranks en so a return home never advances the animation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div   <= '0;
      frame <= '0;
    end else if (clear) begin
      div   <= '0;
      frame <= '0;
    end else if (en) begin
      if (div_last) begin
        div   <= '0;
        frame <= frame_last ? '0 : frame + FW'(1);
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/npc_sprite.sv
// NPC sprite controller: game state FSM, N-frame animation and facing.
// Define NPC_PATROL_EN for horizontal patrol between X_MIN and X_MAX.
module npc_sprite
  import npc_pkg::*;
#(
  parameter int INIT_X     = 280,
  parameter int INIT_Y     = 27,
  parameter int X_MIN      = 200,
  parameter int X_MAX      = 360,
  parameter int STEP       = 1,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 16,
  localparam int FW = $clog2(NUM_FRAMES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           start,
  input  logic           over,
  input  logic           pause,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     state,
  output logic [FW-1:0]  frame,
  output logic           facing
);

  if (X_MIN > INIT_X || INIT_X > X_MAX || X_MAX >= 640 || STEP < 1 ||
      STEP > X_MAX - X_MIN || NUM_FRAMES < 2 || FRAME_DIV < 1) begin : g_bad_params
    $error("npc_sprite: parameter set out of range");
  end

  npc_state_t st_q, st_d;
  logic       go_home;
  logic       tick_apply;
  logic       frame_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= IDLE;
    else      st_q <= st_d;
  end

  // over always wins; start is ignored while over is still asserted.
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (start && !over) st_d = PLAYING;
      PLAYING: if (over) st_d = IDLE; else if (pause) st_d = PAUSED;
      PAUSED:  if (over) st_d = IDLE; else if (!pause) st_d = PLAYING;
      default: st_d = IDLE;
    endcase
  end

  // A tick counts only from PLAYING and never on the way back to IDLE.
  assign go_home    = (st_d == IDLE);
  assign tick_apply = tick && (st_q == PLAYING) && !go_home;

  assign state = st_q;
  assign y     = Y_W'(INIT_Y);

  npc_anim_div #(
    .NUM_FRAMES(NUM_FRAMES),
    .FRAME_DIV (FRAME_DIV)
  ) u_anim (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_apply),
    .clear(go_home),
    .frame(frame),
    .wrap (frame_wrap)
  );

`ifdef NPC_PATROL_EN
  localparam logic [X_W:0] STEP_E = (X_W + 1)'(STEP);
  localparam logic [X_W:0] XMIN_E = (X_W + 1)'(X_MIN);
  localparam logic [X_W:0] XMAX_E = (X_W + 1)'(X_MAX);

  logic unused_wrap;
  assign unused_wrap = frame_wrap;

  // Bound comparisons use one extra bit so x+STEP cannot overflow and the
  // left check never subtracts from x.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x      <= X_W'(INIT_X);
      facing <= DIR_RIGHT;
    end else if (go_home) begin
      x      <= X_W'(INIT_X);
      facing <= DIR_RIGHT;
    end else if (tick_apply) begin
      if (facing == DIR_RIGHT) begin
        if ({1'b0, x} + STEP_E >= XMAX_E) begin
          x      <= X_W'(X_MAX);
          facing <= DIR_LEFT;
        end else begin
          x <= x + X_W'(STEP);
        end
      end else begin
        if ({1'b0, x} <= XMIN_E + STEP_E) begin
          x      <= X_W'(X_MIN);
          facing <= DIR_RIGHT;
        end else begin
          x <= x - X_W'(STEP);
        end
      end
    end
  end
`else
  assign x = X_W'(INIT_X);

  // Legacy sway: flip facing once per complete animation cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            facing <= DIR_RIGHT;
    else if (go_home)    facing <= DIR_RIGHT;
    else if (frame_wrap) facing <= ~facing;
  end
`endif

endmodule

// File: tb/tb_npc_sprite.sv
// Directed bench for npc_sprite: default instance plus a 2-frame instance
// sharing the same stimulus; expectations adapt to NPC_PATROL_EN.
module tb_npc_sprite;

`ifdef NPC_PATROL_EN
  localparam bit PATROL = 1'b1;
`else
  localparam bit PATROL = 1'b0;
`endif

  logic clk;
  logic rst;
  logic tick;
  logic start;
  logic over;
  logic pause;

  logic [9:0] x1, x2;
  logic [8:0] y1, y2;
  logic [1:0] state1, state2;
  logic [1:0] frame1;
  logic [0:0] frame2;
  logic       facing1, facing2;

  int tests_run    = 0;
  int tests_failed = 0;

  npc_sprite u_dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .over(over), .pause(pause),
    .x(x1), .y(y1), .state(state1), .frame(frame1), .facing(facing1)
  );

  npc_sprite #(.NUM_FRAMES(2), .FRAME_DIV(16)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .over(over), .pause(pause),
    .x(x2), .y(y2), .state(state2), .frame(frame2), .facing(facing2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; over = 1'b0; pause = 1'b0;
    cycle(2);
    chk("rst_state", 32'(state1), 0);
    chk("rst_x", 32'(x1), 280);
    chk("rst_y", 32'(y1), 27);
    chk("rst_frame", 32'(frame1), 0);
    chk("rst_facing", 32'(facing1), 1);
    chk("rst_facing2", 32'(facing2), 1);

    rst = 1'b1;
    cycle(1);
    start = 1'b1; over = 1'b1;
    cycle(1);
    chk("start_with_over", 32'(state1), 0);
    over = 1'b0;
    cycle(1);
    start = 1'b0;
    chk("start_state", 32'(state1), 1);
    chk("start_x", 32'(x1), 280);
    chk("start_frame", 32'(frame1), 0);
    chk("start_facing", 32'(facing1), 1);

    do_ticks(15);
    chk("t15_frame", 32'(frame1), 0);
    do_ticks(1);
    chk("t16_frame", 32'(frame1), 1);
    chk("t16_frame2", 32'(frame2), 1);
    do_ticks(16);
    chk("t32_frame", 32'(frame1), 2);
    chk("t32_facing", 32'(facing1), 1);
    chk("t32_frame2", 32'(frame2), 0);
    chk("t32_facing2", 32'(facing2), PATROL ? 1 : 0);
    chk("t32_x", 32'(x1), PATROL ? 312 : 280);
    do_ticks(32);
    chk("t64_frame", 32'(frame1), 0);
    chk("t64_facing", 32'(facing1), PATROL ? 1 : 0);
    chk("t64_facing2", 32'(facing2), 1);
    chk("t64_x", 32'(x1), PATROL ? 344 : 280);

    cycle(3);
    chk("notick_frame", 32'(frame1), 0);
    chk("notick_x", 32'(x1), PATROL ? 344 : 280);

    do_ticks(15);
    chk("t79_x", 32'(x1), PATROL ? 359 : 280);
    chk("t79_facing", 32'(facing1), PATROL ? 1 : 0);
    do_ticks(1);
    chk("t80_x", 32'(x1), PATROL ? 360 : 280);
    chk("t80_facing", 32'(facing1), 0);
    do_ticks(1);
    chk("t81_x", 32'(x1), PATROL ? 359 : 280);
    chk("t81_frame", 32'(frame1), 1);

    pause = 1'b1; tick = 1'b1;
    cycle(1);
    chk("pause_state", 32'(state1), 2);
    chk("pause_tick_x", 32'(x1), PATROL ? 358 : 280);
    cycle(20);
    tick = 1'b0;
    chk("paused_state", 32'(state1), 2);
    chk("paused_x", 32'(x1), PATROL ? 358 : 280);
    chk("paused_frame", 32'(frame1), 1);
    chk("paused_facing", 32'(facing1), 0);
    pause = 1'b0;
    cycle(1);
    chk("resume_state", 32'(state1), 1);
    do_ticks(15);
    chk("t97_x", 32'(x1), PATROL ? 343 : 280);
    chk("t97_frame", 32'(frame1), 2);
    chk("t97_frame2", 32'(frame2), 0);
    chk("t97_facing2", 32'(facing2), 0);
    do_ticks(16);
    chk("t113_frame", 32'(frame1), 3);
    chk("t113_x", 32'(x1), PATROL ? 327 : 280);

    pause = 1'b1;
    cycle(1);
    chk("pause2_state", 32'(state1), 2);
    over = 1'b1;
    cycle(1);
    over = 1'b0; pause = 1'b0;
    chk("over_state", 32'(state1), 0);
    chk("over_x", 32'(x1), 280);
    chk("over_frame", 32'(frame1), 0);
    chk("over_facing", 32'(facing1), 1);
    chk("over_facing2", 32'(facing2), 1);

    start = 1'b1;
    cycle(1);
    start = 1'b0;
    chk("restart_state", 32'(state1), 1);
    do_ticks(15);
    chk("div_cleared_f0", 32'(frame1), 0);
    do_ticks(1);
    chk("div_cleared_f1", 32'(frame1), 1);

    over = 1'b1; pause = 1'b1; tick = 1'b1;
    cycle(1);
    over = 1'b0; pause = 1'b0; tick = 1'b0;
    chk("over_prio_state", 32'(state1), 0);
    chk("over_prio_frame", 32'(frame1), 0);
    chk("over_prio_x", 32'(x1), 280);

    start = 1'b1;
    cycle(1);
    start = 1'b0;
    do_ticks(20);
    chk("pre_arst_frame", 32'(frame1), 1);
    chk("pre_arst_x", 32'(x1), PATROL ? 300 : 280);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(state1), 0);
    chk("arst_frame", 32'(frame1), 0);
    chk("arst_x", 32'(x1), 280);
    chk("arst_facing", 32'(facing1), 1);
    cycle(1);
    rst = 1'b1;
    cycle(1);
    chk("post_arst_state", 32'(state1), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
